ssd_cmd_scheduler: RTL and testbench

SSD_CMD_SCHEDULER -- requirements
Module: ssd_cmd_scheduler

---
 rtl/ssd_sched_pkg.sv | 19 +
 rtl/rr_arb2.sv | 33 +++
 rtl/ssd_cmd_scheduler.sv | 151 +++++++++++++++
 tb/tb_ssd_cmd_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_sched_pkg.sv
// Shared types and sizing constants for the SSD command scheduler.
package ssd_sched_pkg;

    localparam int unsigned SCHED_CMD_W = 45;
    localparam int unsigned SCHED_CNT_W = 16;
    localparam int unsigned SCHED_TO_W  = 24;

    // Request index positions inside the arbiter request/grant vectors
    localparam int unsigned REQ_RD = 0;
    localparam int unsigned REQ_WR = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FAULT
    } sched_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; one-hot grant, pointer advances only on accept.
module rr_arb2
    import ssd_sched_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic r_last_wr;

    // On a tie the requester that did not win last time is granted
    always_comb begin
        o_grant = '0;
        if (i_req == 2'b11) begin
            o_grant[REQ_WR] = ~r_last_wr;
            o_grant[REQ_RD] = r_last_wr;
        end else begin
            o_grant = i_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_last_wr <= 1'b0;
        end else if (i_accept) begin
            r_last_wr <= o_grant[REQ_WR];
        end
    end

endmodule

// File: rtl/ssd_cmd_scheduler.sv
// Arbitrates memcached read/write commands onto a single SSD command port,
// keeping one command outstanding and faulting when a completion never arrives.
module ssd_cmd_scheduler
    import ssd_sched_pkg::*;
#(
    parameter logic [SCHED_TO_W-1:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter int unsigned           CMD_W          = SCHED_CMD_W,
    parameter int unsigned           CNT_W          = SCHED_CNT_W
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [CMD_W-1:0] rd_cmd_data,
    input  logic             rd_cmd_valid,
    output logic             rd_cmd_ready,
    input  logic [CMD_W-1:0] wr_cmd_data,
    input  logic             wr_cmd_valid,
    output logic             wr_cmd_ready,
    output logic [CMD_W:0]   cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic             cmd_done,
    input  logic             cmd_fail,
    input  logic             clr_err,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] rd_issued_cnt,
    output logic [CNT_W-1:0] wr_issued_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [SCHED_TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - 1'b1;

    sched_state_e          r_state;
    sched_state_e          w_next_state;
    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_accept;
    logic                  w_issue_hs;
    logic                  w_fail_evt;
    logic [CMD_W:0]        r_cmd_data;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_fail_cnt;
    logic [SCHED_TO_W-1:0] r_to_cnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .nReset   (nReset),
        .i_req    ({wr_cmd_valid, rd_cmd_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Readies are gated by reset so nothing is accepted while nReset is low
    assign w_idle       = (r_state == ST_IDLE) && nReset;
    assign rd_cmd_ready = w_idle && w_grant[REQ_RD];
    assign wr_cmd_ready = w_idle && w_grant[REQ_WR];
    assign w_rd_acc     = rd_cmd_valid && rd_cmd_ready;
    assign w_wr_acc     = wr_cmd_valid && wr_cmd_ready;
    assign w_accept     = w_rd_acc || w_wr_acc;
    assign w_issue_hs   = (r_state == ST_ISSUE) && cmd_ready;
    assign w_fail_evt   = (r_state == ST_WAIT) && cmd_fail;

    assign busy          = (r_state != ST_IDLE);
    assign cmd_data      = r_cmd_data;
    assign rd_issued_cnt = r_rd_cnt;
    assign wr_issued_cnt = r_wr_cnt;
    assign fail_cnt      = r_fail_cnt;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A completion in the timeout cycle takes priority over the fault
    always_comb begin
        w_next_state = r_state;
        cmd_valid    = 1'b0;
        timeout_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done || cmd_fail) begin
                    w_next_state = ST_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_FAULT: begin
                timeout_err = 1'b1;
                if (clr_err) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_cmd_data <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_fail_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (w_rd_acc) begin
                r_cmd_data <= {rd_cmd_data, 1'b0};
            end else if (w_wr_acc) begin
                r_cmd_data <= {wr_cmd_data, 1'b1};
            end

            if (w_issue_hs) begin
                if (r_cmd_data[0]) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Coincident done+fail counts as a fail
            if (w_fail_evt) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_cmd_scheduler.sv
// Scoreboard bench for ssd_cmd_scheduler: randomized rounds against a
// transaction-level model of grant order, counters and fault timing.
module tb_ssd_cmd_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nReset;
    logic [44:0] rd_cmd_data, wr_cmd_data;
    logic        rd_cmd_valid, rd_cmd_ready, wr_cmd_valid, wr_cmd_ready;
    logic [45:0] cmd_data;
    logic        cmd_valid, cmd_ready, cmd_done, cmd_fail, clr_err;
    logic        busy, timeout_err;
    logic [15:0] rd_issued_cnt, wr_issued_cnt, fail_cnt;

    logic [7:0]  w2_rd_data, w2_wr_data;
    logic        w2_rd_valid, w2_rd_ready, w2_wr_valid, w2_wr_ready;
    logic [8:0]  w2_cmd_data;
    logic        w2_cmd_valid, w2_cmd_ready, w2_done, w2_fail, w2_clr;
    logic        w2_busy, w2_to_err;
    logic [3:0]  w2_rd_cnt, w2_wr_cnt, w2_fail_cnt;

    ssd_cmd_scheduler #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .nReset(nReset),
        .rd_cmd_data(rd_cmd_data), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .wr_cmd_data(wr_cmd_data), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .cmd_fail(cmd_fail), .clr_err(clr_err),
        .busy(busy), .timeout_err(timeout_err),
        .rd_issued_cnt(rd_issued_cnt), .wr_issued_cnt(wr_issued_cnt), .fail_cnt(fail_cnt)
    );

    // Narrow-counter instance so the wrap from all-ones to zero is reachable quickly
    ssd_cmd_scheduler #(.TIMEOUT_CYCLES(24'd16), .CMD_W(8), .CNT_W(4)) dut_wrap (
        .clk(clk), .nReset(nReset),
        .rd_cmd_data(w2_rd_data), .rd_cmd_valid(w2_rd_valid), .rd_cmd_ready(w2_rd_ready),
        .wr_cmd_data(w2_wr_data), .wr_cmd_valid(w2_wr_valid), .wr_cmd_ready(w2_wr_ready),
        .cmd_data(w2_cmd_data), .cmd_valid(w2_cmd_valid), .cmd_ready(w2_cmd_ready),
        .cmd_done(w2_done), .cmd_fail(w2_fail), .clr_err(w2_clr),
        .busy(w2_busy), .timeout_err(w2_to_err),
        .rd_issued_cnt(w2_rd_cnt), .wr_issued_cnt(w2_wr_cnt), .fail_cnt(w2_fail_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [45:0] exp_q[$];
    int          m_rd, m_wr, m_fail;
    bit          m_last_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nReset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("cmd_unexpected", cmd_data, 64'hDEAD);
            end else begin
                logic [45:0] e;
                e = exp_q.pop_front();
                check("cmd_data", cmd_data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle();
        check("idle_busy", busy, 0);
        check("idle_timeout_err", timeout_err, 0);
        check("idle_cmd_valid", cmd_valid, 0);
        check("rd_issued_cnt", rd_issued_cnt, m_rd);
        check("wr_issued_cnt", wr_issued_cnt, m_wr);
        check("fail_cnt", fail_cnt, m_fail);
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_readies", {rd_cmd_ready, wr_cmd_ready}, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_counters", {rd_issued_cnt, wr_issued_cnt, fail_cnt}, 0);
    endtask

    // pat: bit0 request read, bit1 request write (0 = random)
    // outcome: 0 done, 1 fail, 2 done+fail, 3 timeout, 4 reset during WAIT
    task automatic run_round(input int pat, input int outcome, input int wait_d);
        bit          g;
        logic [45:0] e;
        int          p;
        int          stall;
        p = (pat == 0) ? int'($urandom_range(1, 3)) : pat;
        if (p[0] && !rd_cmd_valid) begin
            rd_cmd_valid = 1'b1;
            rd_cmd_data  = 45'({$urandom(), $urandom()});
        end
        if (p[1] && !wr_cmd_valid) begin
            wr_cmd_valid = 1'b1;
            wr_cmd_data  = 45'({$urandom(), $urandom()});
        end
        #1;
        if (rd_cmd_valid && wr_cmd_valid) g = !m_last_wr;
        else g = wr_cmd_valid;
        e = g ? {wr_cmd_data, 1'b1} : {rd_cmd_data, 1'b0};
        exp_q.push_back(e);
        m_last_wr = g;
        check("rd_ready_grant", rd_cmd_ready, !g);
        check("wr_ready_grant", wr_cmd_ready, g);
        tick();
        if (g) wr_cmd_valid = 1'b0;
        else rd_cmd_valid = 1'b0;
        check("cmd_valid_latency", cmd_valid, 1);
        check("issue_busy", busy, 1);
        stall = $urandom_range(0, 5);
        for (int s = 0; s < stall; s++) begin
            cmd_done = 1'($urandom());
            cmd_fail = 1'($urandom());
            tick();
            check("stall_cmd_valid", cmd_valid, 1);
            check("stall_cmd_data", cmd_data, e);
            check("stall_readies", {rd_cmd_ready, wr_cmd_ready}, 0);
        end
        cmd_done  = 1'b0;
        cmd_fail  = 1'b0;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        if (g) m_wr++;
        else m_rd++;
        check("wait_readies", {rd_cmd_ready, wr_cmd_ready}, 0);
        check("wait_cmd_valid", cmd_valid, 0);
        check("issued_after_hs", {rd_issued_cnt, wr_issued_cnt}, {16'(m_rd), 16'(m_wr)});
        case (outcome)
            0, 1, 2: begin
                repeat (wait_d) tick();
                cmd_done = (outcome != 1);
                cmd_fail = (outcome != 0);
                tick();
                cmd_done = 1'b0;
                cmd_fail = 1'b0;
                if (outcome != 0) m_fail++;
                check_idle();
            end
            3: begin
                for (int k = 1; k <= 15; k++) begin
                    tick();
                    check("timeout_early", timeout_err, 0);
                end
                tick();
                check("timeout_fault", timeout_err, 1);
                check("fault_cmd_valid", cmd_valid, 0);
                check("fault_busy", busy, 1);
                if (!rd_cmd_valid) begin
                    rd_cmd_valid = 1'b1;
                    rd_cmd_data  = 45'({$urandom(), $urandom()});
                end
                repeat (3) begin
                    cmd_done = 1'b1;
                    cmd_fail = 1'b1;
                    tick();
                    check("fault_hold", timeout_err, 1);
                    check("fault_readies", {rd_cmd_ready, wr_cmd_ready}, 0);
                end
                cmd_done = 1'b0;
                cmd_fail = 1'b0;
                clr_err  = 1'b1;
                tick();
                clr_err  = 1'b0;
                check_idle();
            end
            default: begin
                repeat (wait_d) tick();
                if (!rd_cmd_valid) begin
                    rd_cmd_valid = 1'b1;
                    rd_cmd_data  = 45'({$urandom(), $urandom()});
                end
                wr_cmd_valid = 1'b0;
                nReset = 1'b0;
                tick();
                check_reset_outputs();
                m_rd = 0; m_wr = 0; m_fail = 0; m_last_wr = 1'b0;
                nReset = 1'b1;
            end
        endcase
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion, expected finish before 5ms");
        $fatal(1);
    end

    initial begin
        int n;
        nReset = 1'b0;
        rd_cmd_valid = 1'b1; rd_cmd_data = 45'h1_2345_6789A;
        wr_cmd_valid = 1'b0; wr_cmd_data = '0;
        cmd_ready = 1'b0; cmd_done = 1'b0; cmd_fail = 1'b0; clr_err = 1'b0;
        w2_rd_data = '0; w2_rd_valid = 1'b0; w2_wr_data = 8'h3C; w2_wr_valid = 1'b0;
        w2_cmd_ready = 1'b0; w2_done = 1'b0; w2_fail = 1'b0; w2_clr = 1'b0;
        m_rd = 0; m_wr = 0; m_fail = 0; m_last_wr = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        nReset = 1'b1;

        run_round(3, 0, 2);   // tie after reset: write first
        run_round(1, 1, 0);   // then the waiting read
        run_round(2, 2, 3);   // done and fail together
        cmd_done = 1'b1; cmd_fail = 1'b1;
        tick();
        cmd_done = 1'b0; cmd_fail = 1'b0;
        tick();
        check_idle();
        run_round(1, 0, 15);  // completion in the timeout cycle
        run_round(2, 3, 0);   // timeout to FAULT
        run_round(1, 4, 3);   // reset during WAIT
        run_round(1, 0, 0);   // read granted after reset release

        for (int i = 0; i < 60; i++) begin
            int o, d;
            o = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            d = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
            run_round(0, o, d);
        end

        w2_cmd_ready = 1'b1; w2_done = 1'b1; w2_wr_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 400 && n < 15; c++) begin
            @(negedge clk);
            if (w2_cmd_valid) n++;
        end
        w2_wr_valid = 1'b0;
        check("wrap_issue_count", n, 15);
        repeat (4) tick();
        check("wrap_at_max", w2_wr_cnt, 4'hF);
        w2_wr_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 1; c++) begin
            @(negedge clk);
            if (w2_cmd_valid) n++;
        end
        w2_wr_valid = 1'b0;
        check("wrap_extra_issue", n, 1);
        repeat (4) tick();
        check("wrap_to_zero", w2_wr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
